// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and drives every datapath enable and select.
// Optional: define RETIRE_COUNT_EN to add the retired_cnt output (counts cycles with PCWre=1).
module multicycle_control_unit #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [ST_W-1:0] state,
  output logic            PCWre,
  output logic            IRWre,
  output logic            RegWre,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic            ExtSel,
  output logic [2:0]      ALUOp,
  output logic [1:0]      RegDst,
  output logic            WrRegDSrc,
  output logic            DBDataSrc,
  output logic            mRD,
  output logic            mWR,
  output logic [1:0]      PCSrc,
  output logic            halted
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]     retired_cnt
`endif
);

  localparam logic [ST_W-1:0] S_IF     = ST_W'(3'd0);
  localparam logic [ST_W-1:0] S_ID     = ST_W'(3'd1);
  localparam logic [ST_W-1:0] S_EXE_LS = ST_W'(3'd2);
  localparam logic [ST_W-1:0] S_MEM    = ST_W'(3'd3);
  localparam logic [ST_W-1:0] S_WB_LD  = ST_W'(3'd4);
  localparam logic [ST_W-1:0] S_EXE_BR = ST_W'(3'd5);
  localparam logic [ST_W-1:0] S_EXE_AL = ST_W'(3'd6);
  localparam logic [ST_W-1:0] S_WB_AL  = ST_W'(3'd7);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

  logic [ST_W-1:0] state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            halted_q, halted_d;
  logic [2:0]      alu_op;
  logic            alu_a, alu_b, alu_ext, alu_imm;

  // ALU selects come from the opcode latched in ID, so the IR input may change after decode
  always_comb begin
    alu_op  = 3'b000;
    alu_a   = 1'b0;
    alu_b   = 1'b0;
    alu_ext = 1'b1;
    alu_imm = 1'b0;
    case (op_q)
      OP_SUB:  alu_op = 3'b001;
      OP_ADDI: begin alu_b = 1'b1; alu_imm = 1'b1; end
      OP_OR:   alu_op = 3'b011;
      OP_AND:  alu_op = 3'b100;
      OP_ORI:  begin alu_op = 3'b011; alu_b = 1'b1; alu_ext = 1'b0; alu_imm = 1'b1; end
      OP_SLL:  begin alu_op = 3'b010; alu_a = 1'b1; end
      OP_SLT:  alu_op = 3'b101;
      default: alu_op = 3'b000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    if (!halted_q) begin
      case (state_q)
        S_IF: begin
          IRWre   = 1'b1;
          state_d = S_ID;
        end
        S_ID: begin
          state_d = S_IF;
          case (opcode)
            OP_J:    begin PCWre = 1'b1; PCSrc = 2'b11; end
            OP_JR:   begin PCWre = 1'b1; PCSrc = 2'b10; end
            OP_JAL:  begin PCWre = 1'b1; PCSrc = 2'b11; RegWre = 1'b1; end
            OP_HALT: halted_d = 1'b1;
            OP_BEQ:  state_d = S_EXE_BR;
            OP_SW, OP_LW: state_d = S_EXE_LS;
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT:
              state_d = S_EXE_AL;
            default: PCWre = 1'b1;
          endcase
        end
        S_EXE_AL: begin
          ALUOp   = alu_op;
          ALUSrcA = alu_a;
          ALUSrcB = alu_b;
          ExtSel  = alu_ext;
          state_d = S_WB_AL;
        end
        S_WB_AL: begin
          ALUOp     = alu_op;
          ALUSrcA   = alu_a;
          ALUSrcB   = alu_b;
          ExtSel    = alu_ext;
          RegWre    = 1'b1;
          RegDst    = alu_imm ? 2'b01 : 2'b10;
          WrRegDSrc = 1'b1;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end
        S_EXE_BR: begin
          ALUOp   = 3'b001;
          PCWre   = 1'b1;
          PCSrc   = zero ? 2'b01 : 2'b00;
          state_d = S_IF;
        end
        S_EXE_LS: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          state_d = S_MEM;
        end
        S_MEM: begin
          // Strobe stays up for the whole stall; only mem_ready lets the FSM leave
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          mRD     = (op_q == OP_LW);
          mWR     = (op_q == OP_SW);
          if (mem_ready) begin
            if (op_q == OP_LW) begin
              state_d = S_WB_LD;
            end else begin
              PCWre   = 1'b1;
              state_d = S_IF;
            end
          end
        end
        S_WB_LD: begin
          RegWre    = 1'b1;
          RegDst    = 2'b01;
          DBDataSrc = 1'b1;
          WrRegDSrc = 1'b1;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IF;
      op_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      if (state_q == S_ID && !halted_q)
        op_q <= opcode;
    end
  end

  assign state  = state_q;
  assign halted = halted_q;

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      retired_cnt <= 32'd0;
    else if (PCWre && !halted_q)
      retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a per-instruction trace model builds the expected output of
// every cycle; a negedge process compares the DUT against it. Honours RETIRE_COUNT_EN if defined.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0] state;
    logic       pcwre, irwre, regwre, srca, srcb, ext;
    logic [2:0] aluop;
    logic [1:0] regdst;
    logic       wrsrc, dbsrc, mrd, mwr;
    logic [1:0] pcsrc;
    logic       halted;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       z;
    logic       mr;
    outs_t      want;
  } cyc_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] state;
  logic       PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc, mRD, mWR, halted;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, PCSrc;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_cnt;
`endif

  outs_t dut_vec;
  cyc_t  plan[$];
  cyc_t  expq[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    exp_ret = 0;
  int    len0;

  multicycle_control_unit #(.OP_W(6), .ST_W(3)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .halted(halted)
`ifdef RETIRE_COUNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {state, PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
                    RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc, halted};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
  endtask

  task automatic apply_stimulus(input logic [5:0] op, input logic z, input logic mr);
    opcode    = op;
    zero      = z;
    mem_ready = mr;
  endtask

  // Every cycle that has a queued expectation is compared mid-cycle
  always @(negedge CLK) begin
    cyc_t c;
    if (expq.size() > 0) begin
      c = expq.pop_front();
      check_output(c.name, 32'(dut_vec), 32'(c.want));
    end
  end

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  task automatic push(input string nm, input logic [5:0] op, input logic z, input logic mr,
                      input outs_t w);
    cyc_t c;
    c.name = nm; c.op = op; c.z = z; c.mr = mr; c.want = w;
    plan.push_back(c);
  endtask

  // Expected trace of one instruction, derived from the instruction class rules
  task automatic model_instr(input string nm, input logic [5:0] op, input logic z, input int stalls);
    outs_t o;
    logic [5:0] junk;
    logic imm;
    junk = ~op;
    o = blank(3'd0); o.irwre = 1'b1;
    push({nm, ".IF"}, op, ~z, 1'b1, o);
    o = blank(3'd1);
    case (op)
      6'b111000, 6'b111001, 6'b111010: begin
        o.pcwre = 1'b1;
        o.pcsrc = (op == 6'b111001) ? 2'b10 : 2'b11;
        if (op == 6'b111010) o.regwre = 1'b1;
        push({nm, ".ID"}, op, ~z, 1'b1, o);
      end
      6'b111111: begin
        push({nm, ".ID"}, op, ~z, 1'b1, o);
        for (int i = 0; i < 10; i++) begin
          o = blank(3'd0); o.halted = 1'b1;
          push({nm, ".HALTED"}, 6'(i), 1'b1, 1'b1, o);
        end
      end
      6'b110100: begin
        push({nm, ".ID"}, op, ~z, 1'b1, o);
        o = blank(3'd5); o.aluop = 3'b001; o.pcwre = 1'b1; o.pcsrc = z ? 2'b01 : 2'b00;
        push({nm, ".EXE_BR"}, junk, z, 1'b1, o);
      end
      6'b110000, 6'b110001: begin
        push({nm, ".ID"}, op, ~z, 1'b1, o);
        o = blank(3'd2); o.srcb = 1'b1; o.ext = 1'b1;
        push({nm, ".EXE_LS"}, junk, z, 1'b0, o);
        for (int i = 0; i <= stalls; i++) begin
          o = blank(3'd3); o.srcb = 1'b1; o.ext = 1'b1;
          o.mrd = op[0];
          o.mwr = ~op[0];
          o.pcwre = (i == stalls) && !op[0];
          push({nm, ".MEM"}, junk, z, (i == stalls), o);
        end
        if (op[0]) begin
          o = blank(3'd4); o.regwre = 1'b1; o.regdst = 2'b01; o.dbsrc = 1'b1;
          o.wrsrc = 1'b1; o.pcwre = 1'b1;
          push({nm, ".WB_LD"}, junk, z, 1'b0, o);
        end
      end
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b011000, 6'b100110: begin
        push({nm, ".ID"}, op, ~z, 1'b1, o);
        o = blank(3'd6); o.ext = 1'b1;
        imm = (op == 6'b000010) || (op == 6'b010010);
        o.srcb = imm;
        o.srca = (op == 6'b011000);
        if (op == 6'b010010) o.ext = 1'b0;
        case (op)
          6'b000001: o.aluop = 3'b001;
          6'b011000: o.aluop = 3'b010;
          6'b010000, 6'b010010: o.aluop = 3'b011;
          6'b010001: o.aluop = 3'b100;
          6'b100110: o.aluop = 3'b101;
          default:   o.aluop = 3'b000;
        endcase
        push({nm, ".EXE_AL"}, junk, z, 1'b0, o);
        o.state = 3'd7; o.regwre = 1'b1; o.regdst = imm ? 2'b01 : 2'b10;
        o.wrsrc = 1'b1; o.pcwre = 1'b1;
        push({nm, ".WB_AL"}, junk, z, 1'b0, o);
      end
      default: begin
        o.pcwre = 1'b1;
        push({nm, ".ID"}, op, ~z, 1'b1, o);
      end
    endcase
  endtask

  // Drives planned cycles from one clock-phase point to the next; limit<0 drains the plan
  task automatic run_plan(input int limit);
    cyc_t c;
    int n;
    n = 0;
    while (plan.size() > 0 && (limit < 0 || n < limit)) begin
      c = plan.pop_front();
      apply_stimulus(c.op, c.z, c.mr);
      expq.push_back(c);
      if (c.want.pcwre) exp_ret++;
      n++;
      @(posedge CLK);
      #1;
    end
    plan.delete();
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b0;
    #1;
    check_output({tag, ".state"}, 32'(state), 32'd0);
    check_output({tag, ".IRWre"}, 32'(IRWre), 32'd1);
    check_output({tag, ".halted"}, 32'(halted), 32'd0);
    exp_ret = 0;
    #1;
    RST = 1'b1;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    do_reset("rst0");

    // Model pinning: trace lengths are the CPI figures and a few hand-encoded cycles
    len0 = plan.size(); model_instr("add", 6'b000000, 1'b0, 0);
    check_output("cpi.add", 32'(plan.size() - len0), 32'd4);
    check_output("pin.add.WB_AL", 32'(plan[plan.size()-1].want), 32'(21'b111_1_0_1_0_0_1_000_10_1_0_0_0_00_0));
    len0 = plan.size(); model_instr("lw", 6'b110001, 1'b0, 3);
    check_output("cpi.lw3", 32'(plan.size() - len0), 32'd8);
    check_output("pin.lw.WB_LD", 32'(plan[plan.size()-1].want), 32'(21'b100_1_0_1_0_0_0_000_01_1_1_0_0_00_0));
    len0 = plan.size(); model_instr("beq1", 6'b110100, 1'b1, 0);
    check_output("cpi.beq", 32'(plan.size() - len0), 32'd3);
    check_output("pin.beq1.EXE_BR", 32'(plan[plan.size()-1].want), 32'(21'b101_1_0_0_0_0_0_001_00_0_0_0_0_01_0));
    model_instr("beq0", 6'b110100, 1'b0, 0);
    len0 = plan.size(); model_instr("jal", 6'b111010, 1'b0, 0);
    check_output("cpi.jal", 32'(plan.size() - len0), 32'd2);
    check_output("pin.jal.ID", 32'(plan[plan.size()-1].want), 32'(21'b001_1_0_1_0_0_0_000_00_0_0_0_0_11_0));
    model_instr("sub",  6'b000001, 1'b0, 0);
    model_instr("addi", 6'b000010, 1'b1, 0);
    model_instr("or",   6'b010000, 1'b0, 0);
    model_instr("and",  6'b010001, 1'b0, 0);
    model_instr("ori",  6'b010010, 1'b0, 0);
    model_instr("sll",  6'b011000, 1'b0, 0);
    model_instr("slt",  6'b100110, 1'b0, 0);
    model_instr("nopA", 6'b000011, 1'b0, 0);
    model_instr("nopB", 6'b101010, 1'b0, 0);
    model_instr("sw1",  6'b110000, 1'b0, 1);
    model_instr("lw0",  6'b110001, 1'b0, 0);
    model_instr("j",    6'b111000, 1'b0, 0);
    model_instr("jr",   6'b111001, 1'b0, 0);
    run_plan(-1);

    // Asynchronous reset while a store is stalled in MEM
    model_instr("swst", 6'b110000, 1'b0, 10);
    run_plan(5);
    check_output("midmem.mWR_before", 32'(mWR), 32'd1);
    RST = 1'b0;
    #1;
    check_output("midmem.state", 32'(state), 32'd0);
    check_output("midmem.IRWre", 32'(IRWre), 32'd1);
    check_output("midmem.mWR", 32'(mWR), 32'd0);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check_output("postrst.state", 32'(state), 32'd1);

    do_reset("rst1");
    model_instr("add2", 6'b000000, 1'b0, 0);
    model_instr("beq2", 6'b110100, 1'b1, 0);
    model_instr("sw0",  6'b110000, 1'b0, 0);
    model_instr("j2",   6'b111000, 1'b0, 0);
    model_instr("nop2", 6'b000111, 1'b0, 0);
    model_instr("halt", 6'b111111, 1'b0, 0);
    run_plan(-1);
    check_output("halt.ret_model", 32'(exp_ret), 32'd5);
`ifdef RETIRE_COUNT_EN
    check_output("retired_cnt", retired_cnt, 32'(exp_ret));
    repeat (3) @(posedge CLK);
    #1;
    check_output("retired_cnt.frozen", retired_cnt, 32'd5);
`endif
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
